logical_eq_arbiter: RTL and testbench
=====================================

Name: logical_eq_arbiter

Overview:
- Shares one N-bit equality comparator (a == b) among NUM_REQ requesters using round-robin arbitration.
- Each requester presents an operand pair under a valid/ready handshake.
- The winning pair is compared and the result is registered into a single-entry response buffer, tagged with the requester ID.
- Sits between requesters in the BasicCombinationalLogic Logical unit and the shared comparator datapath.

Parameters:
- N, 8, operand width in bits (N >= 1).
- NUM_REQ, 4, number of requesters (2..16).
- IDW (localparam), $clog2(NUM_REQ), width of the requester ID.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*N  packed operand A; requester i uses bits [i*N +: N].
- req_b  input  NUM_REQ*N  packed operand B; same packing as req_a.
- rsp_valid  output  1  response buffer holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  IDW  index of the requester that produced the result.
- rsp_eq  output  1  1 when req_a[i] == req_b[i] at grant time, else 0.

Behaviour:
- Reset (rst=1 at a clock edge):
  - rsp_valid=0, rsp_id=0, rsp_eq=0.
  - Round-robin pointer ptr=0.
  - Reset mid-transaction drops the buffered response; the requester is not re-granted automatically.
- Handshake events:
  - req_fire[i] = req_valid[i] & req_ready[i].
  - rsp_fire = rsp_valid & rsp_ready.
- Buffer free condition (combinational): slot_free = !rsp_valid | rsp_ready.
- Grant (combinational, same cycle):
  - If slot_free and any req_valid, grant the first valid requester searching ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - req_ready = one-hot of that requester; otherwise req_ready=0.
  - req_ready may depend on req_valid and rsp_ready; it never depends on a registered grant.
- Compare and capture:
  - The granted pair passes through one comparator instance (single shared mux + ==).
  - On req_fire, the next edge sets rsp_valid=1, rsp_id=granted index, rsp_eq=compare result.
  - Latency: result appears the cycle after acceptance.
- Pointer update: on req_fire, ptr <= (granted index + 1) mod NUM_REQ. With no grant, ptr holds.
- Buffer pop: rsp_fire with no new req_fire sets rsp_valid<=0; rsp_id and rsp_eq hold their last values.
- Pop and refill in the same cycle: rsp_fire and a new req_fire overwrite the buffer with the new result, rsp_valid stays 1. Full throughput is one result per cycle.
- Backpressure: while rsp_valid=1 and rsp_ready=0:
  - req_ready=0.
  - rsp_valid, rsp_id and rsp_eq are stable.
- Fairness: a continuously valid requester is granted within NUM_REQ grants.
- Requester inputs while req_ready[i]=0 are ignored. Requesters must hold valid and data until ready; the block does not check this.
- rsp_eq compares all N bits. An X/Z input yields X (no special handling).

Optional Feature:
- Macro: LOGICAL_EQ_ARBITER_STATS_EN.
- When defined, adds output port match_count [15:0]:
  - Increments by 1 on each rsp_fire with rsp_eq=1.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by rst.
- When undefined, the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert rst with req_valid=4'b1111 -> rsp_valid=0 and req_ready=0 that cycle. First grant after reset goes to requester 0.
- Single request: requester 2 valid with a=8'hA5, b=8'hA5, rsp_ready=1 -> req_ready=4'b0100. Next cycle rsp_valid=1, rsp_id=2, rsp_eq=1. With a=8'hA5, b=8'hA4 -> rsp_eq=0.
- Round-robin: all four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0. One response per cycle, rsp_id sequence matches.
- Backpressure: buffered result, rsp_ready=0 for 5 cycles -> req_ready=0 and outputs stable. When rsp_ready=1, same-cycle pop and refill, rsp_valid never drops.
- Wrap and skip: ptr=3, only requester 1 valid -> grant 1, then ptr=2. Reset mid-stream with rsp_valid=1 -> rsp_valid=0 next cycle.
- Stats (with LOGICAL_EQ_ARBITER_STATS_EN): 3 equal and 2 unequal responses popped -> match_count=3. Equal responses held under rsp_ready=0 -> no increment.

Source files
------------

// File: rtl/logical_eq_arbiter.sv
// logical_eq_arbiter: round-robin sharing of one N-bit a==b comparator among NUM_REQ requesters; ports clk, rst, req_valid/req_ready/req_a/req_b (packed per requester), rsp_valid/rsp_ready/rsp_id/rsp_eq, optional match_count when LOGICAL_EQ_ARBITER_STATS_EN is defined
module logical_eq_arbiter #(
  parameter int N = 8,
  parameter int NUM_REQ = 4,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*N-1:0] req_a,
  input  logic [NUM_REQ*N-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_eq
`ifdef LOGICAL_EQ_ARBITER_STATS_EN
  ,
  output logic [15:0]          match_count
`endif
);
  logic [IDW-1:0] ptr, gnt, idx;
  logic any, go;
  int j;
  always_comb begin
    gnt = '0;
    any = 1'b0;
    j = 0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      j = j >= NUM_REQ ? j - NUM_REQ : j;
      idx = IDW'(j);
      if (req_valid[idx]) begin
        gnt = idx;
        any = 1'b1;
      end
    end
  end
  // Reset also blocks acceptance so nothing is handshaken in a cycle whose result is dropped.
  assign go = any & (!rsp_valid | rsp_ready) & !rst;
  assign req_ready = go ? {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_eq <= 1'b0;
      ptr <= '0;
    end else if (go) begin
      rsp_valid <= 1'b1;
      rsp_id <= gnt;
      rsp_eq <= req_a[gnt*N +: N] == req_b[gnt*N +: N];
      ptr <= gnt == IDW'(NUM_REQ - 1) ? '0 : gnt + 1'b1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
`ifdef LOGICAL_EQ_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) match_count <= '0;
    else if (rsp_valid & rsp_ready & rsp_eq & (match_count != 16'hFFFF)) match_count <= match_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_logical_eq_arbiter.sv
// tb_logical_eq_arbiter: randomized scoreboard bench for logical_eq_arbiter
module tb_logical_eq_arbiter;
  localparam int N = 8;
  localparam int R = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [R-1:0] req_valid = '0;
  logic [R-1:0] req_ready;
  logic [R*N-1:0] req_a = '0;
  logic [R*N-1:0] req_b = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [1:0] rsp_id;
  logic rsp_eq;
  logic [N-1:0] a_d [R];
  logic [N-1:0] b_d [R];
  typedef struct {int id; bit eq;} rsp_t;
  rsp_t q[$];
  int vecs = 0;
  int miss = 0;
  int ptr_m = 0;
  bit full_m = 0;
`ifdef LOGICAL_EQ_ARBITER_STATS_EN
  logic [15:0] match_count;
  int exp_mc = 0;
`endif
  logical_eq_arbiter #(.N(N), .NUM_REQ(R)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_eq(rsp_eq)
`ifdef LOGICAL_EQ_ARBITER_STATS_EN
    , .match_count(match_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // One cycle: drive at negedge, then predict the grant from the round-robin rule.
  task automatic step(input logic r, input logic [R-1:0] v, input logic rr, output int g);
    logic [R-1:0] er;
    @(negedge clk);
    rst = r;
    req_valid = v;
    rsp_ready = rr;
    for (int i = 0; i < R; i++) begin
      req_a[i*N +: N] = a_d[i];
      req_b[i*N +: N] = b_d[i];
    end
    #2;
    g = -1;
    if (!r && (!full_m || rr))
      for (int k = 0; k < R; k++)
        if (g < 0 && v[(ptr_m + k) % R]) g = (ptr_m + k) % R;
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    if (r) begin
      q.delete();
      full_m = 0;
      ptr_m = 0;
`ifdef LOGICAL_EQ_ARBITER_STATS_EN
      exp_mc = 0;
`endif
    end else if (g >= 0) begin
      q.push_back('{g, a_d[g] == b_d[g]});
      ptr_m = (g + 1) % R;
      full_m = 1;
    end else if (rr) full_m = 0;
  endtask
  initial begin
    forever begin
      @(negedge clk);
      #1;
      chk("rsp_valid", 32'(rsp_valid), 32'(q.size() != 0));
`ifdef LOGICAL_EQ_ARBITER_STATS_EN
      chk("match_count", 32'(match_count), 32'(exp_mc));
`endif
      if (rsp_valid && rsp_ready && q.size() > 0) begin
        rsp_t e;
        e = q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_eq", 32'(rsp_eq), 32'(e.eq));
`ifdef LOGICAL_EQ_ARBITER_STATS_EN
        if (!rst && e.eq && exp_mc < 65535) exp_mc++;
`endif
      end
    end
  end
  initial begin
    int g;
    logic [R-1:0] v;
    for (int i = 0; i < R; i++) begin
      a_d[i] = 8'(i);
      b_d[i] = 8'(i);
    end
    step(1, '1, 1, g);
    step(1, '1, 1, g);
    a_d[2] = 8'hA5; b_d[2] = 8'hA5;
    step(0, 4'b0100, 1, g);
    b_d[2] = 8'hA4;
    step(0, 4'b0100, 1, g);
    step(0, 4'b0000, 1, g);
    step(1, '1, 1, g);
    for (int i = 0; i < R; i++) begin
      a_d[i] = 8'($urandom);
      b_d[i] = i[0] ? a_d[i] : 8'($urandom);
    end
    repeat (8) step(0, '1, 1, g);
    repeat (6) step(0, '1, 0, g);
    repeat (3) step(0, '1, 1, g);
    step(0, 4'b0100, 1, g);
    step(0, 4'b0010, 1, g);
    step(0, 4'b1111, 1, g);
    v = '0;
    repeat (400) begin
      for (int i = 0; i < R; i++)
        if (!v[i] && $urandom_range(0, 2) != 0) begin
          v[i] = 1'b1;
          a_d[i] = 8'($urandom);
          b_d[i] = $urandom_range(0, 1) != 0 ? a_d[i] : 8'($urandom);
        end
      step(0, v, $urandom_range(0, 3) != 0, g);
      if (g >= 0) v[g] = 1'b0;
    end
    step(0, '1, 0, g);
    step(1, '1, 0, g);
    step(0, '0, 1, g);
    step(0, '1, 1, g);
    repeat (3) step(0, '0, 1, g);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
